// File: rtl/otbn_pkg.sv
// Shared OTBN definitions used by the bignum register file lanes.
package otbn_pkg;

   localparam int unsigned BignumLanes = 8;

   typedef enum logic [1:0] {
      RfWipeIdle   = 2'd0,
      RfWipeActive = 2'd1,
      RfWipeDone   = 2'd2
   } rf_wipe_state_e;

endpackage

// File: rtl/otbn_rf_lane_ff.sv
// One register-file lane: LaneW flops with wipe, port-A and port-B writes in
// descending priority.
module otbn_rf_lane_ff #(
   parameter int unsigned LaneW = 39
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wipe_i,
   input  logic [LaneW-1:0] wipe_val_i,
   input  logic             we_a_i,
   input  logic [LaneW-1:0] wd_a_i,
   input  logic             we_b_i,
   input  logic [LaneW-1:0] wd_b_i,
   output logic [LaneW-1:0] q_o
);

   logic [LaneW-1:0] lane_d, lane_q;

   always_comb begin
      lane_d = lane_q;
      if (wipe_i) begin
         lane_d = wipe_val_i;
      end else if (we_a_i) begin
         lane_d = wd_a_i;
      end else if (we_b_i) begin
         lane_d = wd_b_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   assign q_o = lane_q;

endmodule

// File: rtl/otbn_rf_bignum_lanes.sv
// Flop-based wide register file with per-lane write enables on two ports,
// optional write-to-read bypass and a one-entry-per-cycle wipe sequencer.
module otbn_rf_bignum_lanes
   import otbn_pkg::*;
#(
   parameter int unsigned       NumRegs     = 32,
   parameter int unsigned       NumLanes    = BignumLanes,
   parameter int unsigned       LaneW       = 39,
   parameter bit                Bypass      = 1'b0,
   parameter logic [LaneW-1:0]  WipeLaneVal = '0,
   localparam int unsigned      AddrW       = $clog2(NumRegs),
   localparam int unsigned      W           = NumLanes * LaneW
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [AddrW-1:0]    wr_addr_a_i,
   input  logic [NumLanes-1:0] wr_en_a_i,
   input  logic [W-1:0]        wr_data_a_i,
   input  logic [AddrW-1:0]    wr_addr_b_i,
   input  logic [NumLanes-1:0] wr_en_b_i,
   input  logic [W-1:0]        wr_data_b_i,
   input  logic [AddrW-1:0]    rd_addr_a_i,
   output logic [W-1:0]        rd_data_a_o,
   input  logic [AddrW-1:0]    rd_addr_b_i,
   output logic [W-1:0]        rd_data_b_o,
   input  logic                wipe_req_i,
   output logic                wipe_busy_o,
   output logic                wipe_done_o,
   output logic                wr_collision_o,
   output logic                wr_dropped_o
);

   localparam logic [AddrW-1:0] LastIdx = AddrW'(NumRegs - 1);

   logic [NumLanes-1:0][LaneW-1:0] rf_data [NumRegs];
   logic [NumLanes-1:0][LaneW-1:0] wd_a, wd_b;
   logic [NumRegs-1:0]             sel_a, sel_b, sel_wipe;
   logic                           valid_a, valid_b, wiping;

   rf_wipe_state_e   state_q, state_d;
   logic [AddrW-1:0] cnt_q, cnt_d;
   logic             coll_q, coll_d, drop_q, drop_d;

   assign wd_a   = wr_data_a_i;
   assign wd_b   = wr_data_b_i;
   assign wiping = (state_q == RfWipeActive);

   // One-hot decode; an address with no matching entry is out of range.
   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_wipe = '0;
      for (int unsigned r = 0; r < NumRegs; r++) begin
         sel_a[r]    = (wr_addr_a_i == AddrW'(r));
         sel_b[r]    = (wr_addr_b_i == AddrW'(r));
         sel_wipe[r] = wiping && (cnt_q == AddrW'(r));
      end
   end

   assign valid_a = |sel_a;
   assign valid_b = |sel_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RfWipeIdle: begin
            if (wipe_req_i) begin
               state_d = RfWipeActive;
               cnt_d   = '0;
            end
         end
         RfWipeActive: begin
            if (cnt_q == LastIdx) begin
               state_d = RfWipeDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RfWipeDone: state_d = RfWipeIdle;
         default:    state_d = RfWipeIdle;
      endcase
   end

   always_comb begin
      drop_d = ((|wr_en_a_i) && (wiping || !valid_a)) ||
               ((|wr_en_b_i) && (wiping || !valid_b));
      coll_d = !wiping && valid_a && (wr_addr_a_i == wr_addr_b_i) &&
               (|(wr_en_a_i & wr_en_b_i));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RfWipeIdle;
         cnt_q   <= '0;
         coll_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coll_q  <= coll_d;
         drop_q  <= drop_d;
      end
   end

   for (genvar r = 0; r < NumRegs; r++) begin : g_reg
      for (genvar l = 0; l < NumLanes; l++) begin : g_lane
         otbn_rf_lane_ff #(
            .LaneW (LaneW)
         ) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wipe_i     (sel_wipe[r]),
            .wipe_val_i (WipeLaneVal),
            .we_a_i     (sel_a[r] && wr_en_a_i[l] && !wiping),
            .wd_a_i     (wd_a[l]),
            .we_b_i     (sel_b[r] && wr_en_b_i[l] && !wiping),
            .wd_b_i     (wd_b[l]),
            .q_o        (rf_data[r][l])
         );
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [AddrW-1:0]               addr;
      logic [NumLanes-1:0][LaneW-1:0] data;

      assign addr = (p == 0) ? rd_addr_a_i : rd_addr_b_i;

      always_comb begin
         data = '0;
         for (int unsigned r = 0; r < NumRegs; r++) begin
            if (addr == AddrW'(r)) begin
               data = rf_data[r];
            end
         end
         // Bypass only forwards writes that will actually land this edge.
         if (Bypass && !wiping) begin
            for (int unsigned l = 0; l < NumLanes; l++) begin
               if (valid_a && (wr_addr_a_i == addr) && wr_en_a_i[l]) begin
                  data[l] = wd_a[l];
               end else if (valid_b && (wr_addr_b_i == addr) && wr_en_b_i[l]) begin
                  data[l] = wd_b[l];
               end
            end
         end
      end
   end

   assign rd_data_a_o    = g_rd[0].data;
   assign rd_data_b_o    = g_rd[1].data;
   assign wipe_busy_o    = wiping;
   assign wipe_done_o    = (state_q == RfWipeDone);
   assign wr_collision_o = coll_q;
   assign wr_dropped_o   = drop_q;

endmodule

// File: tb/tb_otbn_rf_bignum_lanes.sv
// Drives two register-file configurations with shared stimulus and checks
// them every cycle against an array-based reference model.
module tb_otbn_rf_bignum_lanes;

   localparam int unsigned LW = 39;
   localparam int unsigned NL = 8;
   localparam int unsigned W  = NL * LW;
   localparam int unsigned AW = 5;
   localparam logic [LW-1:0] WV0 = 39'h4A_C35A_9617;
   localparam logic [LW-1:0] WV1 = 39'h13_0F0F_F0F0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
   logic [NL-1:0] wr_en_a, wr_en_b;
   logic [W-1:0]  wr_data_a, wr_data_b;
   logic          wipe_req;

   logic [W-1:0]  rd_a0, rd_b0, rd_a1, rd_b1;
   logic          busy0, done0, coll0, drop0;
   logic          busy1, done1, coll1, drop1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   otbn_rf_bignum_lanes #(
      .NumRegs(32), .NumLanes(NL), .LaneW(LW), .Bypass(1'b0), .WipeLaneVal(WV0)
   ) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_addr_a_i(wr_addr_a), .wr_en_a_i(wr_en_a), .wr_data_a_i(wr_data_a),
      .wr_addr_b_i(wr_addr_b), .wr_en_b_i(wr_en_b), .wr_data_b_i(wr_data_b),
      .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rd_a0),
      .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rd_b0),
      .wipe_req_i(wipe_req), .wipe_busy_o(busy0), .wipe_done_o(done0),
      .wr_collision_o(coll0), .wr_dropped_o(drop0)
   );

   otbn_rf_bignum_lanes #(
      .NumRegs(24), .NumLanes(NL), .LaneW(LW), .Bypass(1'b1), .WipeLaneVal(WV1)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_addr_a_i(wr_addr_a), .wr_en_a_i(wr_en_a), .wr_data_a_i(wr_data_a),
      .wr_addr_b_i(wr_addr_b), .wr_en_b_i(wr_en_b), .wr_data_b_i(wr_data_b),
      .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rd_a1),
      .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rd_b1),
      .wipe_req_i(wipe_req), .wipe_busy_o(busy1), .wipe_done_o(done1),
      .wr_collision_o(coll1), .wr_dropped_o(drop1)
   );

   // Reference model: per-instance lane storage and wipe progress.
   logic [LW-1:0] mem [2][32][NL];
   int            widx [2];
   bit            mdone [2], mcoll [2], mdrop [2];
   int            nregs [2] = '{32, 24};
   bit            byp [2] = '{1'b0, 1'b1};
   logic [LW-1:0] wval [2] = '{WV0, WV1};

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] fill(input logic [LW-1:0] v);
      return {NL{v}};
   endfunction

   function automatic logic [W-1:0] exp_rd(input int i, input logic [AW-1:0] a);
      logic [W-1:0] v;
      v = '0;
      if (int'(a) >= nregs[i]) return '0;
      for (int l = 0; l < NL; l++) v[l*LW +: LW] = mem[i][a][l];
      if (byp[i] && widx[i] < 0) begin
         for (int l = 0; l < NL; l++) begin
            if (wr_en_a[l] && wr_addr_a == a) v[l*LW +: LW] = wr_data_a[l*LW +: LW];
            else if (wr_en_b[l] && wr_addr_b == a) v[l*LW +: LW] = wr_data_b[l*LW +: LW];
         end
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 32; r++)
            for (int l = 0; l < NL; l++) mem[i][r][l] = '0;
         widx[i]  = -1;
         mdone[i] = 1'b0;
         mcoll[i] = 1'b0;
         mdrop[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit wip, va, vb, od, nd, nc;
      if (!rst_n) return;
      for (int i = 0; i < 2; i++) begin
         wip = (widx[i] >= 0);
         va  = (int'(wr_addr_a) < nregs[i]);
         vb  = (int'(wr_addr_b) < nregs[i]);
         nd  = ((|wr_en_a) && (wip || !va)) || ((|wr_en_b) && (wip || !vb));
         nc  = !wip && va && (wr_addr_a == wr_addr_b) && (|(wr_en_a & wr_en_b));
         od  = mdone[i];
         mdone[i] = 1'b0;
         if (wip) begin
            for (int l = 0; l < NL; l++) mem[i][widx[i]][l] = wval[i];
            if (widx[i] == nregs[i] - 1) begin
               widx[i]  = -1;
               mdone[i] = 1'b1;
            end else begin
               widx[i]++;
            end
         end else begin
            for (int l = 0; l < NL; l++) begin
               if (vb && wr_en_b[l]) mem[i][wr_addr_b][l] = wr_data_b[l*LW +: LW];
               if (va && wr_en_a[l]) mem[i][wr_addr_a][l] = wr_data_a[l*LW +: LW];
            end
            if (!od && wipe_req) widx[i] = 0;
         end
         mcoll[i] = nc;
         mdrop[i] = nd;
      end
   endtask

   task automatic check_all();
      check("rd_a0", rd_a0, exp_rd(0, rd_addr_a));
      check("rd_b0", rd_b0, exp_rd(0, rd_addr_b));
      check("rd_a1", rd_a1, exp_rd(1, rd_addr_a));
      check("rd_b1", rd_b1, exp_rd(1, rd_addr_b));
      check("busy0", W'(busy0), W'(widx[0] >= 0));
      check("busy1", W'(busy1), W'(widx[1] >= 0));
      check("done0", W'(done0), W'(mdone[0]));
      check("done1", W'(done1), W'(mdone[1]));
      check("coll0", W'(coll0), W'(mcoll[0]));
      check("coll1", W'(coll1), W'(mcoll[1]));
      check("drop0", W'(drop0), W'(mdrop[0]));
      check("drop1", W'(drop1), W'(mdrop[1]));
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en_a  = '0;
      wr_en_b  = '0;
      wipe_req = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32 + 1; k++) v = {v[W-33:0], 32'($urandom)};
      for (int l = 0; l < NL; l++) v[l*LW] = 1'b1;
      return v;
   endfunction

   task automatic wait_idle();
      int budget;
      idle();
      budget = 100;
      while ((widx[0] >= 0 || widx[1] >= 0 || mdone[0] || mdone[1]) && budget > 0) begin
         step();
         budget--;
      end
      check("idle_wait", W'(budget == 0), W'(0));
   endtask

   initial begin
      int d0, d1, nb0, nb1, nd0, nd1;
      wr_addr_a = '0; wr_addr_b = '0; rd_addr_a = '0; rd_addr_b = '0;
      wr_data_a = '0; wr_data_b = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // Basic write/read.
      rd_addr_a = 5; rd_addr_b = 6;
      step();
      wr_addr_a = 5; wr_en_a = '1; wr_data_a = fill(39'h1A_5A5A_5A5A);
      step();
      idle(); rd_addr_a = 5; rd_addr_b = 5;
      step();
      check("reg5", rd_a0, fill(39'h1A_5A5A_5A5A));
      rd_addr_b = 6;
      step();

      // Same-register collision, A over B.
      wr_addr_a = 3; wr_en_a = 8'h0F; wr_data_a = fill(39'h11_1111_1111);
      wr_addr_b = 3; wr_en_b = 8'hFC; wr_data_b = fill(39'h22_2222_2222);
      rd_addr_a = 3; rd_addr_b = 3;
      step();
      idle();
      check("coll_flag", W'(coll0), W'(1));
      check("reg3", rd_a0, {fill(39'h22_2222_2222) >> (4*LW) << (4*LW)} |
                            (fill(39'h11_1111_1111) >> (4*LW)));
      step();
      check("coll_clr", W'(coll0), W'(0));

      // Bypass of a single lane.
      wr_addr_b = 7; wr_en_b = '1; wr_data_b = fill(39'h05_0505_0505);
      step();
      idle();
      wr_addr_a = 7; wr_en_a = 8'h01; wr_data_a = '0; wr_data_a[LW-1:0] = 39'h7F;
      rd_addr_b = 7;
      #1;
      check("byp7", rd_b1, {fill(39'h05_0505_0505) >> LW << LW} | W'(39'h7F));
      step();
      idle();

      // Randomised traffic, including occasional wipes.
      for (int n = 0; n < 400; n++) begin
         wr_addr_a = AW'($urandom_range(0, 31));
         wr_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_a : AW'($urandom_range(0, 31));
         wr_en_a   = ($urandom_range(0, 2) == 0) ? '0 : NL'($urandom);
         wr_en_b   = ($urandom_range(0, 2) == 0) ? '0 : NL'($urandom);
         wr_data_a = rand_data();
         wr_data_b = rand_data();
         rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr_a : AW'($urandom_range(0, 31));
         rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr_b : AW'($urandom_range(0, 31));
         wipe_req  = ($urandom_range(0, 49) == 0);
         step();
      end
      wait_idle();

      // Preload, then a full wipe with a write in the 10th busy cycle.
      for (int r = 0; r < 32; r++) begin
         wr_addr_a = AW'(r); wr_en_a = '1; wr_data_a = rand_data();
         step();
      end
      idle();
      wipe_req = 1'b1;
      step();
      wipe_req = 1'b0;
      d0 = 0; d1 = 0; nb0 = 0; nb1 = 0;
      for (int c = 1; c <= 36; c++) begin
         if (busy0) nb0++;
         if (busy1) nb1++;
         if (done0) d0 = c;
         if (done1) d1 = c;
         if (c == 11) begin
            check("wipe_drop0", W'(drop0), W'(1));
            check("wipe_drop1", W'(drop1), W'(1));
         end
         idle();
         if (c == 10) begin
            wr_addr_a = 4; wr_en_a = '1; wr_data_a = rand_data();
         end
         rd_addr_a = AW'(c - 1);
         rd_addr_b = AW'($urandom_range(0, 31));
         step();
      end
      check("busy_len0", W'(nb0), W'(32));
      check("busy_len1", W'(nb1), W'(24));
      check("done_at0", W'(d0), W'(33));
      check("done_at1", W'(d1), W'(25));
      idle();
      for (int r = 0; r < 32; r++) begin
         rd_addr_a = AW'(r); rd_addr_b = AW'(31 - r);
         step();
      end
      check("wiped0", rd_a0, fill(WV0));

      // Reset in the 12th busy cycle.
      wipe_req = 1'b1;
      step();
      wipe_req = 1'b0;
      for (int c = 1; c <= 11; c++) step();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      check("rst_busy0", W'(busy0), W'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nd0 = 0; nd1 = 0;
      for (int c = 0; c < 40; c++) begin
         rd_addr_a = AW'(c % 32); rd_addr_b = AW'((c + 7) % 32);
         step();
         if (done0) nd0++;
         if (done1) nd1++;
      end
      check("rst_nodone0", W'(nd0), W'(0));
      check("rst_nodone1", W'(nd1), W'(0));

      // Out-of-range address on the 24-entry instance.
      wr_addr_a = 30; wr_en_a = '1; wr_data_a = rand_data();
      step();
      idle();
      check("oor_drop1", W'(drop1), W'(1));
      check("oor_drop0", W'(drop0), W'(0));
      rd_addr_a = 30; rd_addr_b = 30;
      step();
      check("oor_rd1", rd_a1, W'(0));
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
